// File: rtl/memory_bridge.sv
// memory_bridge: turns the controller's single-beat memory handshake into a registered req/ack bus access.
// One access is outstanding at a time; a bus error or a response timeout completes it as an access fault.
module memory_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_enable,
    input  logic        memory_command,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_data,
    input  logic [3:0]  memory_write_strobe,
    output logic        memory_ready,
    output logic        memory_valid,
    output logic [31:0] memory_read_data,
    output logic        access_fault,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_write_strobe,
    input  logic        bus_ack,
    input  logic [31:0] bus_read_data,
    input  logic        bus_error
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQUEST, RESPOND} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q, addr_q, wdata_q;
    logic [3:0]    strb_q;
    logic          write_q, fault_q, timeout;

    assign timeout          = TIMEOUT_CYCLES != 0 && cnt_q == LAST;
    assign memory_ready     = state_q == IDLE;
    assign memory_valid     = state_q == RESPOND;
    assign bus_request      = state_q == REQUEST;
    assign memory_read_data = rdata_q;
    assign access_fault     = fault_q;
    assign bus_write        = write_q;
    assign bus_address      = addr_q;
    assign bus_write_data   = wdata_q;
    assign bus_write_strobe = strb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (memory_enable) begin
                    state_q <= REQUEST;
                    write_q <= memory_command;
                    addr_q  <= {memory_address[31:2], 2'b00};
                    wdata_q <= memory_write_data;
                    strb_q  <= memory_command ? memory_write_strobe : 4'b0000;
                    cnt_q   <= '0;
                end
                REQUEST: if (bus_ack) begin
                    state_q <= RESPOND;
                    fault_q <= bus_error;
                    // Only a successful read refreshes the returned data.
                    if (!write_q && !bus_error) rdata_q <= bus_read_data;
                end else if (timeout) begin
                    state_q <= RESPOND;
                    fault_q <= 1'b1;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                RESPOND: begin
                    state_q <= IDLE;
                    fault_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_bridge.sv
// tb_memory_bridge: two bridges (timeout disabled, timeout of 4) share one stimulus stream
// and are checked cycle by cycle against a transaction-level model.
module tb_memory_bridge;
    logic        clk = 1'b0, reset = 1'b0, en = 1'b0, cmd = 1'b0, ack = 1'b0, err = 1'b0;
    logic [31:0] addr = '0, wd = '0, brd = '0;
    logic [3:0]  st = '0;
    logic [1:0]  rdy, vld, flt, req, bw;
    logic [31:0] ba [2], bwd [2], rd [2];
    logic [3:0]  bs [2];
    logic [31:0] rd_m [2];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        memory_bridge #(.TIMEOUT_CYCLES(g * 4)) u_dut (
            .clk(clk), .reset(reset),
            .memory_enable(en), .memory_command(cmd), .memory_address(addr),
            .memory_write_data(wd), .memory_write_strobe(st),
            .memory_ready(rdy[g]), .memory_valid(vld[g]), .memory_read_data(rd[g]),
            .access_fault(flt[g]), .bus_request(req[g]), .bus_write(bw[g]),
            .bus_address(ba[g]), .bus_write_data(bwd[g]), .bus_write_strobe(bs[g]),
            .bus_ack(ack), .bus_read_data(brd), .bus_error(err)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_state(input int d, input logic er, input logic eq, input logic ev,
                             input logic ef, input logic [31:0] erd);
        check($sformatf("d%0d memory_ready", d), 32'(rdy[d]), 32'(er));
        check($sformatf("d%0d bus_request", d), 32'(req[d]), 32'(eq));
        check($sformatf("d%0d memory_valid", d), 32'(vld[d]), 32'(ev));
        check($sformatf("d%0d access_fault", d), 32'(flt[d]), 32'(ef));
        check($sformatf("d%0d memory_read_data", d), rd[d], erd);
    endtask

    task automatic chk_bus(input int d, input logic c, input logic [31:0] a, input logic [31:0] w,
                           input logic [3:0] s);
        check($sformatf("d%0d bus_write", d), 32'(bw[d]), 32'(c));
        check($sformatf("d%0d bus_address", d), ba[d], a & 32'hFFFF_FFFC);
        check($sformatf("d%0d bus_write_data", d), bwd[d], w);
        check($sformatf("d%0d bus_write_strobe", d), 32'(bs[d]), 32'(c ? s : 4'b0000));
    endtask

    // One access with bus_ack pulsed in cycle j after acceptance (j-1 wait states).
    task automatic xact(input logic c, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                        input int j, input logic e, input logic [31:0] rdat, input bit noise);
        int ed [2];
        logic f [2];
        logic [31:0] nr [2];
        bit to;
        for (int i = 0; i < 2; i++) begin
            to = i * 4 != 0 && j > i * 4;
            ed[i] = to ? i * 4 : j;
            f[i] = to || e;
            nr[i] = (!to && !c && !e) ? rdat : rd_m[i];
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk_state(i, 1'b1, 1'b0, 1'b0, 1'b0, rd_m[i]);
        en = 1'b1; cmd = c; addr = a; wd = w; st = s; ack = 1'b0;
        for (int n = 1; n <= (ed[0] > ed[1] ? ed[0] : ed[1]) + 2; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk_state(i, n >= ed[i] + 2, n <= ed[i], n == ed[i] + 1, n == ed[i] + 1 && f[i],
                          n <= ed[i] ? rd_m[i] : nr[i]);
                if (n <= ed[i]) chk_bus(i, c, a, w, s);
            end
            en   = (noise && n < (ed[0] < ed[1] ? ed[0] : ed[1]) + 2) ? 1'($urandom_range(1)) : 1'b0;
            cmd  = 1'($urandom);
            addr = $urandom;
            wd   = $urandom;
            st   = 4'($urandom);
            ack  = n == j;
            err  = n == j ? e : 1'($urandom);
            brd  = n == j ? rdat : $urandom;
        end
        for (int i = 0; i < 2; i++) rd_m[i] = nr[i];
        ack = 1'b0; en = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        en = 1'b1; cmd = 1'b1; addr = $urandom; wd = $urandom; st = 4'hF;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 2; i++) check($sformatf("d%0d req before reset", i), 32'(req[i]), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk_state(i, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
            chk_bus(i, 1'b0, 32'd0, 32'd0, 4'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; ack = 1'b1; err = 1'b0; brd = $urandom;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ack = 1'b0;
            for (int i = 0; i < 2; i++) chk_state(i, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        end
        for (int i = 0; i < 2; i++) rd_m[i] = '0;
    endtask

    // memory_enable held high with a zero-wait bus: one capture every third cycle.
    task automatic held(input int k);
        logic c = 1'b0;
        logic [31:0] a = '0, w = '0, r = '0;
        logic [3:0] s = '0;
        int p;
        ack = 1'b1; err = 1'b0;
        for (int n = 0; n < 3 * k; n++) begin
            @(negedge clk);
            p = n % 3;
            for (int i = 0; i < 2; i++) begin
                chk_state(i, p == 0, p == 1, p == 2, 1'b0, (p == 2 && !c) ? r : rd_m[i]);
                if (p == 1) chk_bus(i, c, a, w, s);
                if (p == 2 && !c) rd_m[i] = r;
            end
            en = 1'b1; cmd = 1'($urandom); addr = $urandom; wd = $urandom; st = 4'($urandom); brd = $urandom;
            if (p == 0) begin c = cmd; a = addr; w = wd; s = st; end
            if (p == 1) r = brd;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) check($sformatf("d%0d ready after held", i), 32'(rdy[i]), 32'd1);
        en = 1'b0; ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk_state(i, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
            chk_bus(i, 1'b0, 32'd0, 32'd0, 4'd0);
            rd_m[i] = '0;
        end
        reset = 1'b1;
        xact(1'b0, 32'h0000_1003, 32'h0, 4'hF, 1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        xact(1'b1, 32'h0000_2006, 32'h1234_5678, 4'b0011, 6, 1'b0, 32'hCAFE_F00D, 1'b0);
        xact(1'b0, 32'h0000_3000, 32'h0, 4'h0, 2, 1'b1, 32'h5555_AAAA, 1'b0);
        xact(1'b0, 32'h0000_4001, 32'h0, 4'h0, 7, 1'b0, 32'h0BAD_F00D, 1'b0);
        xact(1'b0, 32'h0000_5002, 32'h0, 4'h0, 4, 1'b0, 32'h7777_1111, 1'b0);
        mid_reset();
        held(5);
        for (int t = 0; t < 40; t++)
            xact(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(9, 1),
                 $urandom_range(3) == 0, $urandom, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
